// File: rtl/hash_target_checker.sv
// Multi-cycle hash < target comparator: one CHUNK slice per cycle, MSB first, early exit on first difference.
// Optional sticky hit interrupt (irq / irq_clr) is built when HIT_IRQ_EN is defined.
module hash_target_checker #(
   parameter int WIDTH   = 256,
   parameter int CHUNK   = 32,
   parameter int NONCE_W = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               target_we,
   input  logic [WIDTH-1:0]   target_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_hash,
   input  logic [NONCE_W-1:0] in_nonce,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_hit,
   output logic [NONCE_W-1:0] out_nonce,
   output logic [CNT_W-1:0]   hit_count,
`ifdef HIT_IRQ_EN
   input  logic               irq_clr,
   output logic               irq,
`endif
   output logic               busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPARE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]         state_reg;
   logic [WIDTH-1:0]   target_reg;
   logic [WIDTH-1:0]   snap_reg;
   logic [WIDTH-1:0]   hash_reg;
   logic [NONCE_W-1:0] nonce_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic               hit_reg;
   logic               lt_reg;
   logic               gt_reg;
   logic               last_reg;
   logic               cmp_vld_reg;
   logic [CNT_W-1:0]   hit_count_reg;

   logic [CHUNK-1:0] hash_slice   [NCHUNK];
   logic [CHUNK-1:0] target_slice [NCHUNK];

   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
         assign hash_slice[gi]   = hash_reg[gi*CHUNK +: CHUNK];
         assign target_slice[gi] = snap_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   logic accept;
   logic transfer;
   logic decide;

   assign in_ready  = (state_reg == IDLE) && !reset;
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign out_hit   = hit_reg;
   assign out_nonce = nonce_reg;
   assign hit_count = hit_count_reg;

   assign accept   = in_valid && in_ready;
   assign transfer = out_valid && out_ready;
   // Slice comparison is registered so the wide slice mux stays off the decision path.
   assign decide   = cmp_vld_reg && (lt_reg || gt_reg || last_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         target_reg    <= '0;
         snap_reg      <= '0;
         hash_reg      <= '0;
         nonce_reg     <= '0;
         idx_reg       <= '0;
         hit_reg       <= 1'b0;
         lt_reg        <= 1'b0;
         gt_reg        <= 1'b0;
         last_reg      <= 1'b0;
         cmp_vld_reg   <= 1'b0;
         hit_count_reg <= '0;
      end else begin
         if (target_we) begin
            target_reg <= target_in;
         end

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  hash_reg    <= in_hash;
                  nonce_reg   <= in_nonce;
                  snap_reg    <= target_reg;
                  idx_reg     <= IDX_TOP;
                  cmp_vld_reg <= 1'b0;
                  state_reg   <= COMPARE;
               end
            end
            COMPARE: begin
               if (decide) begin
                  hit_reg   <= lt_reg;
                  state_reg <= DONE;
               end else begin
                  lt_reg      <= hash_slice[idx_reg] < target_slice[idx_reg];
                  gt_reg      <= hash_slice[idx_reg] > target_slice[idx_reg];
                  last_reg    <= (idx_reg == '0);
                  cmp_vld_reg <= 1'b1;
                  if (idx_reg != '0) begin
                     idx_reg <= idx_reg - IDX_W'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (transfer && hit_reg && (hit_count_reg != {CNT_W{1'b1}})) begin
            hit_count_reg <= hit_count_reg + CNT_W'(1);
         end
      end
   end

`ifdef HIT_IRQ_EN
   logic irq_reg;

   // A new hit outranks a clear arriving on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_reg <= 1'b0;
      end else if (transfer && hit_reg) begin
         irq_reg <= 1'b1;
      end else if (irq_clr) begin
         irq_reg <= 1'b0;
      end
   end

   assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_hash_target_checker.sv
// Randomized scoreboard bench for hash_target_checker; the irq checks are compiled in with HIT_IRQ_EN.
module tb_hash_target_checker;
   localparam int WIDTH   = 256;
   localparam int CHUNK   = 32;
   localparam int NCHUNK  = WIDTH / CHUNK;
   localparam int NONCE_W = 32;
   localparam int CNT_W   = 3;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               target_we = 1'b0;
   logic [WIDTH-1:0]   target_in = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [WIDTH-1:0]   in_hash = '0;
   logic [NONCE_W-1:0] in_nonce = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic               out_hit;
   logic [NONCE_W-1:0] out_nonce;
   logic [CNT_W-1:0]   hit_count;
   logic               busy;
`ifdef HIT_IRQ_EN
   logic               irq_clr = 1'b0;
   logic               irq;
`endif

   hash_target_checker #(
      .WIDTH(WIDTH), .CHUNK(CHUNK), .NONCE_W(NONCE_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .target_we(target_we), .target_in(target_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_hash(in_hash), .in_nonce(in_nonce),
      .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_nonce(out_nonce),
      .hit_count(hit_count),
`ifdef HIT_IRQ_EN
      .irq_clr(irq_clr), .irq(irq),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic               hit;
      logic [NONCE_W-1:0] nonce;
      int                 lat;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int unsigned cyc = 0;
   int unsigned accept_cyc = 0;
   logic [WIDTH-1:0] model_target = '0;
   int model_count = 0;
   logic model_irq = 1'b0;
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;
   logic held_hit = 1'b0;
   logic [NONCE_W-1:0] held_nonce = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_wide();
      logic [WIDTH-1:0] v;
      for (int k = 0; k < NCHUNK; k++) begin
         v[k*CHUNK +: CHUNK] = ($urandom_range(0, 3) == 0) ? '0 : CHUNK'($urandom);
      end
      return v;
   endfunction

   // Slices from the MSB until the first difference; a full match scans all of them.
   function automatic int first_diff(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] t);
      for (int k = 0; k < NCHUNK; k++) begin
         if (h[WIDTH-1-k*CHUNK -: CHUNK] != t[WIDTH-1-k*CHUNK -: CHUNK]) return k;
      end
      return NCHUNK - 1;
   endfunction

   // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         model_count = 0;
         model_irq = 1'b0;
      end else begin
         if (in_valid && in_ready) accept_cyc = cyc + 1;
`ifdef HIT_IRQ_EN
         check("irq", {63'd0, irq}, {63'd0, model_irq});
`endif
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) check("unexpected_result", 64'd1, 64'd0);
            else check("latency", 64'(cyc - accept_cyc), 64'(sb[0].lat));
         end
         if (prev_valid && !prev_ready) begin
            check("valid_hold", {63'd0, out_valid}, 64'd1);
            check("hit_hold", {63'd0, out_hit}, {63'd0, held_hit});
            check("nonce_hold", 64'(out_nonce), 64'(held_nonce));
         end
         if (out_valid) check("in_ready_busy", {63'd0, in_ready}, 64'd0);
         if (out_valid && out_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("hit", {63'd0, out_hit}, {63'd0, e.hit});
            check("nonce", 64'(out_nonce), 64'(e.nonce));
            check("hit_count", 64'(hit_count), 64'(model_count));
            $display("result nonce=%h hit=%0d lat=%0d count=%0d", out_nonce, out_hit, e.lat, hit_count);
            if (e.hit && model_count < (1 << CNT_W) - 1) model_count++;
`ifdef HIT_IRQ_EN
            if (e.hit) model_irq = 1'b1;
            else if (irq_clr) model_irq = 1'b0;
         end else if (irq_clr) begin
            model_irq = 1'b0;
`endif
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         held_hit = out_hit;
         held_nonce = out_nonce;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_target(input logic [WIDTH-1:0] t);
      target_in = t;
      target_we = 1'b1;
      tick();
      target_we = 1'b0;
      model_target = t;
   endtask

   task automatic send(input logic [WIDTH-1:0] h, input logic [NONCE_W-1:0] n, input int hold,
                       input bit mid_we, input logic [WIDTH-1:0] new_t);
      exp_t e;
      int w;
      bit do_we;
      w = 0;
      out_ready = 1'b0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 64'd0, 64'd1);
         return;
      end
      in_hash = h;
      in_nonce = n;
      in_valid = 1'b1;
      e.hit = (h < model_target);
      e.nonce = n;
      e.lat = first_diff(h, model_target) + 2;
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      w = 0;
      while (sb.size() > 0 && w < 200) begin
         do_we = (mid_we && w == 0) || ($urandom_range(0, 15) == 0);
         if (do_we) begin
            target_in = (mid_we && w == 0) ? new_t : rand_wide();
            target_we = 1'b1;
         end
         out_ready = (w < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
`ifdef HIT_IRQ_EN
         irq_clr = ($urandom_range(0, 2) == 0);
`endif
         tick();
         if (do_we) begin
            model_target = target_in;
            target_we = 1'b0;
         end
         w++;
      end
      out_ready = 1'b0;
`ifdef HIT_IRQ_EN
      irq_clr = 1'b0;
`endif
      if (sb.size() > 0) begin
         check("result_timeout", 64'd0, 64'd1);
         sb.delete();
      end
   endtask

   logic [WIDTH-1:0] t1;
   logic [WIDTH-1:0] h;

   initial begin
      tick();
      tick();
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hit_count", 64'(hit_count), 64'd0);
      check("rst_out_hit", {63'd0, out_hit}, 64'd0);
      check("rst_out_nonce", 64'(out_nonce), 64'd0);
      reset = 1'b0;
      #1;
      check("idle_in_ready", {63'd0, in_ready}, 64'd1);

      // Directed: slice-1 hit, slice-0 miss, full-equal miss, LSB-only hit.
      t1 = {32'h0, 32'hFFFF0000, 192'h0};
      set_target(t1);
      send({32'h0, 32'h0000FFFF, 192'h0}, 32'hDEADBEEF, 0, 1'b0, '0);
      send({32'h1, 224'h0}, 32'h00000002, 0, 1'b0, '0);
      send(t1, 32'h00000003, 0, 1'b0, '0);
      set_target({224'h0ABC, 32'h12345678});
      send(model_target - 1, 32'h00000004, 0, 1'b0, '0);
      // Stall in DONE and clear the target mid-compare; the in-flight job keeps its snapshot.
      set_target(t1);
      send({32'h0, 32'h0000FFFF, 192'h0}, 32'h00000005, 9, 1'b1, '0);
      send({32'h0, 32'h0000FFFF, 192'h0}, 32'h00000006, 0, 1'b0, '0);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) set_target(rand_wide());
         h = model_target;
         case ($urandom_range(0, 3))
            0: h = rand_wide();
            1: ;
            default: begin
               int j;
               j = $urandom_range(0, NCHUNK - 1);
               h[j*CHUNK +: CHUNK] = CHUNK'($urandom);
            end
         endcase
         send(h, NONCE_W'($urandom), $urandom_range(0, 3), 1'b0, '0);
      end

      // Abort a long compare with reset in its second cycle.
      set_target({32'h5, 224'h0});
      send({32'h4, 224'h0}, 32'h0000AAAA, 0, 1'b0, '0);
      in_hash = model_target;
      in_nonce = 32'h0000BBBB;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_hit_count", 64'(hit_count), 64'd0);
      reset = 1'b0;
      model_target = '0;
      #1;
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      send({32'h0, 224'h1}, 32'h0000CCCC, 0, 1'b0, '0);
      set_target({32'h9, 224'h0});
      send({32'h8, 224'h0}, 32'h0000DDDD, 0, 1'b0, '0);
      tick();
      check("final_hit_count", 64'(hit_count), 64'(model_count));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
